// File: rtl/regfile_16_pkg.sv
// Shared sizing constants for the register bank, its write decoder and the read muxes.
package regfile_16_pkg;

   localparam int REG_COUNT = 16;
   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = 4'd0;

   typedef logic [ADDR_W-1:0] reg_addr_t;

   // A bypassed read needs an active write to the address being read.
   // The hardwired r0 never bypasses.
   function automatic logic bypass_hit(input logic we, input reg_addr_t wr_addr,
                                       input reg_addr_t rd_addr, input logic r0_zero);
      return we && (wr_addr == rd_addr) && !(r0_zero && (rd_addr == ZERO_REG));
   endfunction

endpackage

// File: rtl/mux_16.sv
// 16-input data mux; the register bank uses one instance per read port.
module mux_16
   import regfile_16_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic [REG_COUNT-1:0][WIDTH-1:0] data,
   input  logic [ADDR_W-1:0]               sel,
   output logic [WIDTH-1:0]                y
);

   assign y = data[sel];

endmodule

// File: rtl/regfile_16_decoder.sv
// One-hot 4-to-16 decoder gated by an enable; drives the per-register write strobes.
module decoder_4to16
   import regfile_16_pkg::*;
(
   input  logic [ADDR_W-1:0]    addr,
   input  logic                 en,
   output logic [REG_COUNT-1:0] sel
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         sel[i] = en && (addr == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/regfile_16.sv
// 16 x WIDTH flip-flop register bank: one synchronous write port, two combinational read ports.
module regfile_16
   import regfile_16_pkg::*;
#(
   parameter int WIDTH   = DATA_W,
   parameter int R0_ZERO = 1,
   parameter int BYPASS  = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ctrl_we,
   input  logic [ADDR_W-1:0] ctrl_write_reg,
   input  logic [WIDTH-1:0]  data_write,
   input  logic [ADDR_W-1:0] ctrl_read_reg_a,
   input  logic [ADDR_W-1:0] ctrl_read_reg_b,
   output logic [WIDTH-1:0]  data_read_a,
   output logic [WIDTH-1:0]  data_read_b
);

   localparam logic R0Z = (R0_ZERO != 0);
   localparam logic BYP = (BYPASS != 0);

   logic [REG_COUNT-1:0]            wr_sel;
   logic [REG_COUNT-1:0]            wr_en;
   logic [REG_COUNT-1:0][WIDTH-1:0] regs;
   logic [WIDTH-1:0]                mux_a;
   logic [WIDTH-1:0]                mux_b;

   decoder_4to16 u_dec (
      .addr (ctrl_write_reg),
      .en   (ctrl_we),
      .sel  (wr_sel)
   );

   always_comb begin
      wr_en = wr_sel;
      if (R0Z) wr_en[ZERO_REG] = 1'b0;
   end

   for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
      if (g == 0 && R0Z) begin : g_zero
         assign regs[g] = '0;
      end else begin : g_ff
         logic [WIDTH-1:0] q;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)      q <= '0;
            else if (wr_en[g]) q <= data_write;
         end
         assign regs[g] = q;
      end
   end

   mux_16 #(.WIDTH(WIDTH)) u_mux_a (
      .data (regs),
      .sel  (ctrl_read_reg_a),
      .y    (mux_a)
   );

   mux_16 #(.WIDTH(WIDTH)) u_mux_b (
      .data (regs),
      .sel  (ctrl_read_reg_b),
      .y    (mux_b)
   );

   // Bypass is gated by reset_n so reads stay zero while reset is held.
   always_comb begin
      data_read_a = mux_a;
      data_read_b = mux_b;
      if (BYP && reset_n) begin
         if (bypass_hit(ctrl_we, ctrl_write_reg, ctrl_read_reg_a, R0Z)) data_read_a = data_write;
         if (bypass_hit(ctrl_we, ctrl_write_reg, ctrl_read_reg_b, R0Z)) data_read_b = data_write;
      end
   end

endmodule

// File: tb/tb_regfile_16.sv
// Randomized bench for regfile_16: three parameter variants checked against one array model.
module tb_regfile_16;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ctrl_we;
   logic [3:0]  ctrl_write_reg;
   logic [31:0] data_write;
   logic [3:0]  ctrl_read_reg_a;
   logic [3:0]  ctrl_read_reg_b;
   logic [31:0] rd_a, rd_b, nz_a, nz_b, bp_a, bp_b;

   int n_chk = 0;
   int n_err = 0;

   // Last value written to each address, including writes to address 0.
   logic [31:0] m [16];

   always #5 clock = ~clock;

   regfile_16 #(.WIDTH(32), .R0_ZERO(1), .BYPASS(0)) dut (
      .clock(clock), .reset_n(reset_n), .ctrl_we(ctrl_we), .ctrl_write_reg(ctrl_write_reg),
      .data_write(data_write), .ctrl_read_reg_a(ctrl_read_reg_a), .ctrl_read_reg_b(ctrl_read_reg_b),
      .data_read_a(rd_a), .data_read_b(rd_b));

   regfile_16 #(.WIDTH(32), .R0_ZERO(0), .BYPASS(0)) dut_nz (
      .clock(clock), .reset_n(reset_n), .ctrl_we(ctrl_we), .ctrl_write_reg(ctrl_write_reg),
      .data_write(data_write), .ctrl_read_reg_a(ctrl_read_reg_a), .ctrl_read_reg_b(ctrl_read_reg_b),
      .data_read_a(nz_a), .data_read_b(nz_b));

   regfile_16 #(.WIDTH(32), .R0_ZERO(1), .BYPASS(1)) dut_bp (
      .clock(clock), .reset_n(reset_n), .ctrl_we(ctrl_we), .ctrl_write_reg(ctrl_write_reg),
      .data_write(data_write), .ctrl_read_reg_a(ctrl_read_reg_a), .ctrl_read_reg_b(ctrl_read_reg_b),
      .data_read_a(bp_a), .data_read_b(bp_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [3:0] ra, input bit r0z, input bit bp);
      if (!reset_n)                                   return 32'd0;
      if (r0z && ra == 4'd0)                          return 32'd0;
      if (bp && ctrl_we && ra == ctrl_write_reg)      return data_write;
      return m[ra];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".a"},    rd_a, exp_rd(ctrl_read_reg_a, 1'b1, 1'b0));
      chk({tag, ".b"},    rd_b, exp_rd(ctrl_read_reg_b, 1'b1, 1'b0));
      chk({tag, ".nz_a"}, nz_a, exp_rd(ctrl_read_reg_a, 1'b0, 1'b0));
      chk({tag, ".nz_b"}, nz_b, exp_rd(ctrl_read_reg_b, 1'b0, 1'b0));
      chk({tag, ".bp_a"}, bp_a, exp_rd(ctrl_read_reg_a, 1'b1, 1'b1));
      chk({tag, ".bp_b"}, bp_b, exp_rd(ctrl_read_reg_b, 1'b1, 1'b1));
   endtask

   // One rising edge; the model takes the write the DUT should take.
   task automatic cycle();
      @(posedge clock);
      if (reset_n && ctrl_we) m[ctrl_write_reg] = data_write;
      #1;
   endtask

   task automatic assert_reset();
      reset_n = 1'b0;
      foreach (m[i]) m[i] = 32'd0;
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      ctrl_we = 1'b1; ctrl_write_reg = addr; data_write = data;
      cycle();
      ctrl_we = 1'b0;
   endtask

   initial begin
      assert_reset();
      ctrl_we = 1'b1; ctrl_write_reg = 4'd5; data_write = 32'hDEADBEEF;
      ctrl_read_reg_a = '0; ctrl_read_reg_b = '0;

      // Reset held across clock edges with a write pending: all reads zero.
      for (int i = 0; i < 16; i++) begin
         ctrl_read_reg_a = 4'(i); ctrl_read_reg_b = 4'(15 - i);
         #2 check_all("rst_sweep");
      end
      @(negedge clock);
      reset_n = 1'b1; ctrl_we = 1'b0;
      ctrl_read_reg_a = 4'd5; ctrl_read_reg_b = 4'd5;
      #1 check_all("rst_release_r5");
      chk("rst_r5_zero", rd_a, 32'd0);

      for (int i = 1; i < 16; i++) wr(4'(i), 32'(100 + i));
      for (int i = 0; i < 16; i++) begin
         ctrl_read_reg_a = 4'(i); ctrl_read_reg_b = 4'(15 - i);
         #1 check_all("sweep");
         chk("sweep_abs_a", rd_a, (i == 0) ? 32'd0 : 32'(100 + i));
      end

      wr(4'd0, 32'hFFFFFFFF);
      ctrl_read_reg_a = 4'd0; ctrl_read_reg_b = 4'd0;
      #1 check_all("r0");
      chk("r0_zero", rd_a, 32'd0);
      chk("r0_nz", nz_a, 32'hFFFFFFFF);

      // Read-during-write on r3.
      wr(4'd3, 32'd7);
      ctrl_we = 1'b1; ctrl_write_reg = 4'd3; data_write = 32'd9;
      ctrl_read_reg_a = 4'd3; ctrl_read_reg_b = 4'd4;
      #1 check_all("rdw_pre");
      chk("rdw_pre_old", rd_a, 32'd7);
      chk("rdw_pre_byp", bp_a, 32'd9);
      cycle();
      ctrl_we = 1'b0;
      #1 check_all("rdw_post");
      chk("rdw_post_new", rd_a, 32'd9);

      // Write enable low leaves r7 untouched.
      ctrl_we = 1'b0; ctrl_write_reg = 4'd7; data_write = 32'h12345678;
      ctrl_read_reg_a = 4'd7;
      cycle();
      check_all("we_low");
      chk("we_low_r7", rd_a, 32'd107);

      // Bypass with address 0 must still read zero.
      ctrl_we = 1'b1; ctrl_write_reg = 4'd0; data_write = 32'hA5A5A5A5;
      ctrl_read_reg_a = 4'd0; ctrl_read_reg_b = 4'd0;
      #1 check_all("byp_r0");
      chk("byp_r0_zero", bp_a, 32'd0);
      cycle();
      ctrl_we = 1'b0;

      for (int n = 0; n < 300; n++) begin
         ctrl_we         = ($urandom_range(0, 3) != 0);
         ctrl_write_reg  = 4'($urandom_range(0, 15));
         data_write      = $urandom;
         ctrl_read_reg_a = ($urandom_range(0, 3) == 0) ? ctrl_write_reg : 4'($urandom_range(0, 15));
         ctrl_read_reg_b = 4'($urandom_range(0, 15));
         #1 check_all("rnd_pre");
         cycle();
         check_all("rnd_post");
      end

      // Asynchronous reset between edges, then a write at an edge with reset still low.
      for (int i = 1; i < 16; i++) wr(4'(i), 32'(200 + i));
      ctrl_read_reg_a = 4'd9; ctrl_read_reg_b = 4'd15;
      #2 assert_reset();
      #1 check_all("async_rst");
      chk("async_rst_a", rd_a, 32'd0);
      ctrl_we = 1'b1; ctrl_write_reg = 4'd5; data_write = 32'hCAFEF00D;
      cycle();
      #2 reset_n = 1'b1; ctrl_we = 1'b0;
      ctrl_read_reg_a = 4'd5; ctrl_read_reg_b = 4'd9;
      #1 check_all("rst_write_lost");
      chk("rst_write_lost_r5", rd_a, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
